// File: rtl/if_fetch.sv
// Instruction fetch stage. A 32-bit instruction is assembled from four
// little-endian byte reads through a shared byte port. The assembled
// instruction is held for the decode stage until it is consumed, or until
// a branch redirects fetching.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic        pending_q, pending_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        issue_open;
  logic        grant_fire;
  logic [23:0] asm_upd;
  logic [31:0] redirect_pc;

  // The low two target bits are dropped so fetching always starts word aligned.
  assign redirect_pc = branch_target_i & 32'hFFFF_FFFC;

  // Byte request: open while fetching and fewer than four bytes have been
  // granted; suppressed entirely while reset is asserted.
  always_comb begin
    issue_open = (state_q == ST_FETCH) && (issue_cnt_q < 3'd4);
    mem_req_o  = issue_open && !rst;
    mem_addr_o = mem_req_o ? (fetch_pc_q + {29'd0, issue_cnt_q}) : 32'd0;
    grant_fire = mem_req_o && mem_grant_i;
  end

  // Lower three byte lanes of the assembly buffer: the lane selected by the
  // receive counter takes the returning byte, the others keep their value.
  // Byte 3 never lands here; it goes straight into the output register.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign asm_upd[gi*8 +: 8] = (recv_cnt_q == 3'(gi)) ? mem_din_i : asm_q[gi*8 +: 8];
  end

  // Next-state logic: branch redirect wins over everything, then per-state
  // issue/collect (FETCH) or present/consume (HOLD).
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pending_d   = 1'b0;
    asm_d       = asm_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;

    if (branch_i) begin
      // Clearing pending drops the byte that answers this cycle's grant.
      state_d     = ST_FETCH;
      fetch_pc_d  = redirect_pc;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 3'd0;
      valid_d     = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (grant_fire) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
            pending_d   = 1'b1;
          end
          if (pending_q) begin
            recv_cnt_d = recv_cnt_q + 3'd1;
            if (recv_cnt_q == 3'd3) begin
              inst_d  = {mem_din_i, asm_q};
              pc_d    = fetch_pc_q;
              valid_d = 1'b1;
              state_d = ST_HOLD;
            end else begin
              asm_d = asm_upd;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            // Instruction consumed at this edge; 32-bit add wraps naturally.
            fetch_pc_d  = fetch_pc_q + 32'd4;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
            valid_d     = 1'b0;
            state_d     = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous reset that abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= 32'd0;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      pending_q   <= 1'b0;
      asm_q       <= 24'd0;
      pc_q        <= 32'd0;
      inst_q      <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pending_q   <= pending_d;
      asm_q       <= asm_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch stage.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        mem_grant_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .mem_grant_i    (mem_grant_i),
    .mem_din_i      (mem_din_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: instruction address being fetched/presented,
  // bytes granted so far for it, and whether it is currently presented.
  logic [31:0] m_pc   = 32'd0;
  int          m_ngnt = 0;
  bit          m_hold = 1'b0;
  bit          m_shown = 1'b0;

  logic        prev_gnt;
  logic [31:0] prev_addr;

  // Memory contents: a fixed program at 0..3, a hash of the address elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ 8'hA5 ^ {a[1:0], 6'b0} ^ a[15:8] ^ a[31:24];
    endcase
  endfunction

  function automatic logic [31:0] ref_inst(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic exp_req;
    exp_req = !rst && !m_hold && (m_ngnt < 4);
    chk("m_req", {31'd0, mem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("m_addr", mem_addr_o, m_pc + 32'(m_ngnt));
    if (rst)     chk("m_addr_rst", mem_addr_o, 32'd0);
    chk("m_valid", {31'd0, inst_valid_o}, {31'd0, m_hold});
    if (m_hold) begin
      chk("m_pc", pc_o, m_pc);
      chk("m_inst", inst_o, ref_inst(m_pc));
      if (!m_shown) $display("txn cycle=%0d pc=%h inst=%h", cyc, pc_o, inst_o);
    end
    m_shown = m_hold;
  endtask

  task automatic model_update();
    if (rst) begin
      m_pc = 32'd0; m_ngnt = 0; m_hold = 1'b0;
    end else if (branch_i) begin
      m_pc = branch_target_i & 32'hFFFF_FFFC; m_ngnt = 0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (!stall_i) begin
        m_pc = m_pc + 32'd4; m_ngnt = 0; m_hold = 1'b0;
      end
    end else if (m_ngnt == 4) begin
      m_hold = 1'b1;
    end else if (mem_grant_i) begin
      m_ngnt++;
    end
  endtask

  // One clock cycle: check the current cycle against the model, advance it,
  // then return the byte for a granted request one cycle later (noise otherwise).
  task automatic tick();
    #2;
    if (cyc > 0) model_check();
    prev_gnt  = mem_req_o && mem_grant_i;
    prev_addr = mem_addr_o;
    model_update();
    @(posedge clk);
    #1;
    mem_din_i = prev_gnt ? mem_byte(prev_addr) : 8'($urandom);
    cyc++;
  endtask

  int lat;

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'd0;
    mem_grant_i = 1'b1; mem_din_i = 8'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);

    // Continuous grant: addresses 0..3 on consecutive cycles, valid in cycle 5
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("seq_req", {31'd0, mem_req_o}, 32'd1);
      chk("seq_addr", mem_addr_o, 32'(k));
      tick();
    end
    #1;
    chk("seq_valid_c4", {31'd0, inst_valid_o}, 32'd0);
    tick();
    stall_i = 1'b1;
    #1;
    chk("seq_valid_c5", {31'd0, inst_valid_o}, 32'd1);
    chk("seq_inst", inst_o, 32'h0010_0513);
    chk("seq_pc", pc_o, 32'd0);

    // Stall three cycles in HOLD
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("stall_pc", pc_o, 32'd0);
      chk("stall_inst", inst_o, 32'h0010_0513);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
      tick();
    end
    stall_i = 1'b0;
    #1;
    chk("release_valid", {31'd0, inst_valid_o}, 32'd1);
    tick();
    #1;
    chk("next_req", {31'd0, mem_req_o}, 32'd1);
    chk("next_addr", mem_addr_o, 32'd4);

    // Grant withheld two cycles while requesting byte 2 of the word at 4
    tick(); tick();
    mem_grant_i = 1'b0;
    #1;
    chk("gnt_hold_addr0", mem_addr_o, 32'd6);
    tick();
    #1;
    chk("gnt_hold_addr1", mem_addr_o, 32'd6);
    chk("gnt_hold_req", {31'd0, mem_req_o}, 32'd1);
    tick();
    mem_grant_i = 1'b1;
    #1;
    chk("gnt_hold_addr2", mem_addr_o, 32'd6);
    lat = 4;
    while (!inst_valid_o && lat < 20) begin tick(); lat++; end
    chk("gnt_latency", 32'(lat), 32'd7);
    chk("gnt_inst", inst_o, ref_inst(32'd4));
    chk("gnt_pc", pc_o, 32'd4);
    tick();

    // Branch to 0x103 during byte 2 of the word at 8
    #1;
    chk("br_addr_c0", mem_addr_o, 32'd8);
    tick(); tick();
    #1;
    chk("br_addr_c2", mem_addr_o, 32'd10);
    branch_i = 1'b1; branch_target_i = 32'h0000_0103;
    tick();
    branch_i = 1'b0;
    #1;
    chk("br_req", {31'd0, mem_req_o}, 32'd1);
    chk("br_addr", mem_addr_o, 32'h0000_0100);
    chk("br_valid", {31'd0, inst_valid_o}, 32'd0);
    lat = 0;
    while (!inst_valid_o && lat < 20) begin tick(); lat++; end
    chk("br_latency", 32'(lat), 32'd5);
    chk("br_pc", pc_o, 32'h0000_0100);
    chk("br_inst", inst_o, ref_inst(32'h0000_0100));

    // Branch while stalled in HOLD (branch wins) to the top word, then wrap
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    tick();
    branch_i = 1'b0; stall_i = 1'b0;
    #1;
    chk("wrap_valid0", {31'd0, inst_valid_o}, 32'd0);
    chk("wrap_addr0", mem_addr_o, 32'hFFFF_FFFC);
    lat = 0;
    while (!inst_valid_o && lat < 20) begin tick(); lat++; end
    chk("wrap_latency", 32'(lat), 32'd5);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_o, ref_inst(32'hFFFF_FFFC));
    tick();
    #1;
    chk("wrap_req", {31'd0, mem_req_o}, 32'd1);
    chk("wrap_addr", mem_addr_o, 32'd0);

    // Reset mid-fetch after two bytes granted
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_restart_addr", mem_addr_o, 32'd0);
    lat = 0;
    while (!inst_valid_o && lat < 20) begin tick(); lat++; end
    chk("mid_latency", 32'(lat), 32'd5);
    chk("mid_inst", inst_o, 32'h0010_0513);
    chk("mid_pc", pc_o, 32'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      mem_grant_i     = ($urandom_range(0, 9) < 7);
      stall_i         = ($urandom_range(0, 9) < 4);
      branch_i        = ($urandom_range(0, 29) == 0);
      branch_target_i = ($urandom_range(0, 3) == 0) ?
                        (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      rst             = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; branch_i = 1'b0; stall_i = 1'b0; mem_grant_i = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
